// File: rtl/sd_pkg.sv
// Shared types, constants and the bit-serial CRC16-CCITT step for the SD SPI
// transmit path.
package sd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    TOKEN = 3'd2,
    DATA  = 3'd3,
    CRC   = 3'd4
  } sd_tx_state_t;

  localparam logic [7:0]  SD_START_TOKEN = 8'hFE;
  localparam logic [15:0] SD_CRC16_POLY  = 16'h1021;

  // One serial step of x^16+x^12+x^5+1, MSB-first data.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc_in, input logic bit_in);
    logic fb;
    fb = crc_in[15] ^ bit_in;
    return {crc_in[14:0], 1'b0} ^ (fb ? SD_CRC16_POLY : 16'h0000);
  endfunction

  function automatic int sd_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sd_crc16_serial.sv
// Bit-serial CRC16-CCITT accumulator, init 0, fed one payload bit per enable.
module sd_crc16_serial
  import sd_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        bit_en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)      crc <= 16'h0000;
    else if (clear)  crc <= 16'h0000;
    else if (bit_en) crc <= crc16_step(crc, bit_in);
  end

endmodule

// File: rtl/sd_tx_engine.sv
// SD-card SPI transmit engine: command frames and single-block data writes
// (start token, payload via ready/valid, CRC16) serialised MSB-first on MOSI.
module sd_tx_engine
  import sd_pkg::*;
#(
  parameter int CMD_BITS    = 48,
  parameter int DATA_W      = 8,
  parameter int BLOCK_BYTES = 512,
  parameter int CRC_EN      = 1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                rising_edge_sclk,
  input  logic                cmd_valid,
  input  logic [CMD_BITS-1:0] cmd_word,
  output logic                cmd_ready,
  input  logic                blk_start,
  input  logic                data_valid,
  input  logic [DATA_W-1:0]   data_word,
  output logic                data_ready,
  output logic                MOSI,
  output logic                busy,
  output logic                done,
  output logic                underrun
);

  localparam int SR_W    = sd_max3(CMD_BITS, DATA_W, 16);
  localparam int BC_W    = $clog2(SR_W) + 1;
  localparam int N_WORDS = BLOCK_BYTES * 8 / DATA_W;
  localparam int WC_W    = $clog2(N_WORDS + 1);

  sd_tx_state_t      state;
  logic [SR_W-1:0]   sr;
  logic [BC_W-1:0]   bit_cnt;
  logic [WC_W-1:0]   word_cnt;
  logic              buf_full;
  logic [DATA_W-1:0] buf_word;
  logic              out_of_reset;
  logic              done_q;
  logic              underrun_q;
  logic [15:0]       crc;
  logic [15:0]       crc_tail;
  logic              mosi_bit;
  logic              in_payload;
  logic              last_bit;
  logic              word_end;
  logic              more_words;
  logic              take_cmd;
  logic              take_blk;
  logic              take_word;

  // Every unit (frame, token, word, CRC) is shifted out of the MSB end.
  function automatic logic [SR_W-1:0] align_top(input logic [SR_W-1:0] v, input int w);
    return v << (SR_W - w);
  endfunction

  assign mosi_bit   = (state == IDLE) ? 1'b1 : sr[SR_W-1];
  assign in_payload = (state == TOKEN) || (state == DATA);
  assign last_bit   = (bit_cnt == BC_W'(1));
  assign word_end   = rising_edge_sclk && in_payload && last_bit;
  assign more_words = (word_cnt < WC_W'(N_WORDS));
  assign take_cmd   = out_of_reset && (state == IDLE) && cmd_valid;
  assign take_blk   = out_of_reset && (state == IDLE) && !cmd_valid && blk_start;
  // A word offered on the boundary strobe is too late for that boundary.
  assign data_ready = in_payload && !buf_full && more_words && !word_end;
  assign take_word  = data_valid && data_ready;
  // The final payload bit is still being absorbed, so fold it in here.
  assign crc_tail   = (CRC_EN != 0) ? crc16_step(crc, mosi_bit) : 16'hFFFF;

  sd_crc16_serial u_crc (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (take_blk),
    .bit_en (rising_edge_sclk && (state == DATA)),
    .bit_in (mosi_bit),
    .crc    (crc)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      sr           <= '1;
      bit_cnt      <= '0;
      word_cnt     <= '0;
      buf_full     <= 1'b0;
      out_of_reset <= 1'b0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
      if (take_word) buf_full <= 1'b1;
      case (state)
        IDLE: begin
          if (take_cmd) begin
            sr      <= align_top(SR_W'(cmd_word), CMD_BITS);
            bit_cnt <= BC_W'(CMD_BITS);
            state   <= CMD;
          end else if (take_blk) begin
            sr       <= align_top(SR_W'(SD_START_TOKEN), 8);
            bit_cnt  <= BC_W'(8);
            word_cnt <= '0;
            buf_full <= 1'b0;
            state    <= TOKEN;
          end
        end
        default: begin
          if (rising_edge_sclk) begin
            if (!last_bit) begin
              sr      <= {sr[SR_W-2:0], 1'b1};
              bit_cnt <= bit_cnt - BC_W'(1);
            end else if (state == CMD || state == CRC) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end else if (state == DATA && !more_words) begin
              sr      <= align_top(SR_W'(crc_tail), 16);
              bit_cnt <= BC_W'(16);
              state   <= CRC;
            end else begin
              word_cnt <= word_cnt + WC_W'(1);
              bit_cnt  <= BC_W'(DATA_W);
              state    <= DATA;
              if (buf_full) begin
                sr       <= align_top(SR_W'(buf_word), DATA_W);
                buf_full <= 1'b0;
              end else begin
                sr         <= '1;
                underrun_q <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  // NOTE: the payload buffer needs no reset; buf_full qualifies its contents.
  always_ff @(posedge clk) begin
    if (take_word) buf_word <= data_word;
  end

  assign cmd_ready = out_of_reset && (state == IDLE);
  assign MOSI      = mosi_bit;
  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign underrun  = underrun_q;

endmodule
